// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB transmit arbiter with a registered one-result-per-cycle broadcast.
// Define CDB_PRIO0_EN to give port 0 (load/store) absolute priority over the round-robin ports.
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [$clog2(NUM_SRC)-1:0] cdb_src
);
  localparam int SRC_W = $clog2(NUM_SRC);
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d, gnt_idx, idx, rr_nxt;
  logic              gnt_vld;
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SRC_W-1:0]  cdb_src_q;
  int                j;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    j       = 0;
    // Walk from the farthest offset down so the port nearest rr_ptr wins last.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = int'(rr_ptr_q) + k;
      j = (j >= NUM_SRC) ? j - NUM_SRC : j;
      idx = SRC_W'(j);
      if (src_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
`ifdef CDB_PRIO0_EN
    if (src_valid[0]) begin
      gnt_vld = 1'b1;
      gnt_idx = '0;
    end
`endif
    gnt_vld   = gnt_vld & rst_n & ~flush;
    src_ready = '0;
    src_ready[gnt_idx] = gnt_vld;
  end
`ifdef CDB_PRIO0_EN
  assign rr_nxt = (gnt_idx == '0) ? rr_ptr_q :
                  (gnt_idx == SRC_W'(NUM_SRC - 1)) ? SRC_W'(1) : gnt_idx + 1'b1;
`else
  assign rr_nxt = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
`endif
  assign rr_ptr_d = flush ? '0 : gnt_vld ? rr_nxt : rr_ptr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= gnt_vld;
      if (gnt_vld) begin
        cdb_tag_q  <= src_tag[gnt_idx*TAG_W +: TAG_W];
        cdb_data_q <= src_data[gnt_idx*DATA_W +: DATA_W];
        cdb_src_q  <= gnt_idx;
      end
    end
  end
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors with hand-computed expectations for cdb_arbiter (4 ports).
module tb_cdb_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [3:0]   src_valid;
  logic [23:0]  src_tag;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic         cdb_valid;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [1:0]   cdb_src;
  int n_tests = 0;
  int n_fail  = 0;
  cdb_arbiter #(.NUM_SRC(4), .TAG_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
    .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_port(input int p, input logic [5:0] t, input logic [31:0] d);
    src_tag[p*6 +: 6]    = t;
    src_data[p*32 +: 32] = d;
  endtask
  task automatic check_bcast(input string tag, input logic [5:0] t, input logic [31:0] d, input logic [1:0] s);
    check({tag, "_vld"}, cdb_valid, 1'b1);
    check({tag, "_tag"}, cdb_tag, t);
    check({tag, "_data"}, cdb_data, d);
    check({tag, "_src"}, cdb_src, s);
  endtask
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    src_valid = 4'b1111;
    src_tag = '0;
    src_data = '0;
    for (int p = 0; p < 4; p++) set_port(p, 6'(p + 1), 32'hA000_0000 + 32'(p));
    #2;
    check("rst_rdy", src_ready, 4'b0000);
    tick();
    tick();
    check("rst_vld", cdb_valid, 1'b0);
    check("rst_tag", cdb_tag, 6'h0);
    check("rst_data", cdb_data, 32'h0);
    check("rst_src", cdb_src, 2'd0);
    rst_n = 1'b1;
    #1;
    check("rel_rdy", src_ready, 4'b0001);
    tick();
    check_bcast("rel", 6'd1, 32'hA000_0000, 2'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_vld", cdb_valid, 1'b0);
    check("midrst_rdy", src_ready, 4'b0000);
    src_valid = 4'b0000;
    #1;
    rst_n = 1'b1;
    tick();
    check("postrst_vld", cdb_valid, 1'b0);
    check("postrst_tag", cdb_tag, 6'h0);
    set_port(2, 6'h15, 32'hDEADBEEF);
    src_valid = 4'b0100;
    #1;
    check("single_rdy", src_ready, 4'b0100);
    tick();
    src_valid = 4'b0000;
    check_bcast("single", 6'h15, 32'hDEADBEEF, 2'd2);
    tick();
    check("single_idle_vld", cdb_valid, 1'b0);
    check("single_idle_tag", cdb_tag, 6'h15);
    check("single_idle_data", cdb_data, 32'hDEADBEEF);
    set_port(3, 6'h00, 32'h1234_5678);
    src_valid = 4'b1000;
    #1;
    check("tag0_rdy", src_ready, 4'b1000);
    tick();
    src_valid = 4'b0000;
    check_bcast("tag0", 6'h00, 32'h1234_5678, 2'd3);
`ifdef CDB_PRIO0_EN
    set_port(0, 6'h21, 32'h0000_0100);
    set_port(1, 6'h22, 32'h0000_0101);
    src_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("prio_rdy", src_ready, 4'b0001);
      tick();
      check_bcast("prio", 6'h21, 32'h0000_0100, 2'd0);
    end
    src_valid = 4'b0010;
    #1;
    check("prio_drop_rdy", src_ready, 4'b0010);
    tick();
    src_valid = 4'b0000;
    check_bcast("prio_drop", 6'h22, 32'h0000_0101, 2'd1);
`else
    for (int p = 0; p < 4; p++) set_port(p, 6'(p + 1), 32'hB000_0000 + 32'(p));
    src_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fair_rdy", src_ready, 4'b0001 << (k % 4));
      tick();
      check_bcast("fair", 6'(k % 4 + 1), 32'hB000_0000 + 32'(k % 4), 2'(k % 4));
    end
    src_valid = 4'b0100;
    tick();
    set_port(0, 6'h07, 32'h0000_0007);
    set_port(1, 6'h08, 32'h0000_0008);
    src_valid = 4'b0011;
    #1;
    check("wrap_rdy0", src_ready, 4'b0001);
    tick();
    check_bcast("wrap0", 6'h07, 32'h0000_0007, 2'd0);
    src_valid = 4'b0010;
    #1;
    check("wrap_rdy1", src_ready, 4'b0010);
    tick();
    check_bcast("wrap1", 6'h08, 32'h0000_0008, 2'd1);
    set_port(3, 6'h33, 32'h0000_0033);
    src_valid = 4'b1010;
    flush = 1'b1;
    #1;
    check("flush_rdy", src_ready, 4'b0000);
    tick();
    flush = 1'b0;
    check("flush_vld", cdb_valid, 1'b0);
    #1;
    check("post_flush_rdy", src_ready, 4'b0010);
    tick();
    src_valid = 4'b0000;
    check_bcast("post_flush", 6'h08, 32'h0000_0008, 2'd1);
`endif
    tick();
    check("final_idle_vld", cdb_valid, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
